// File: rtl/seq_frame_tx_1101_if.sv
// Payload handshake between an upstream producer and seq_frame_tx_1101.
`timescale 1ns/1ps
interface seq_frame_tx_1101_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/seq_frame_tx_1101.sv
// Serial frame transmitter: sync word, MSB-first payload, optional even parity,
// then a forced run of idle zeros so a downstream 1101 detector can resynchronise.
`timescale 1ns/1ps
module seq_frame_tx_1101 #(
    parameter int       DATA_W    = 8,
    parameter logic [3:0] SYNC    = 4'b1101,
    parameter bit       PARITY_EN = 1'b1,
    parameter int       GAP_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_frame_tx_1101_if.slave   hs,
    output logic                 out,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int MAXV = (DATA_W > GAP_W) ? ((DATA_W > 4) ? DATA_W : 4)
                                           : ((GAP_W  > 4) ? GAP_W  : 4);
    localparam int CW   = $clog2(MAXV);

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP} state_t;

    state_t            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic              par_q, par_d;
    logic              out_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            payload_q  <= '0;
            par_q      <= 1'b0;
            out        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            payload_q  <= payload_d;
            par_q      <= par_d;
            out        <= out_d;
            frame_done <= done_d;
        end
    end

    // out/frame_done are registered, so they are decoded from the next state:
    // the bit for (state_q, cnt_q) is on the line while that state is current.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        par_d     = par_q;
        out_d     = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hs.valid_in) begin
                    state_d   = S_SYNC;
                    cnt_d     = cnt_t'(3);
                    payload_d = hs.data_in;
                    par_d     = ^hs.data_in;
                end
            end
            S_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = cnt_t'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    if (PARITY_EN) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = cnt_t'(GAP_W - 1);
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_PARITY: begin
                state_d = S_GAP;
                cnt_d   = cnt_t'(GAP_W - 1);
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_SYNC:   out_d = SYNC[cnt_d[1:0]];
            S_DATA: begin
                out_d  = payload_d[cnt_d];
                done_d = !PARITY_EN && (cnt_d == '0);
            end
            S_PARITY: begin
                out_d  = par_d;
                done_d = 1'b1;
            end
            default:  out_d = 1'b0;
        endcase
    end

    assign hs.ready_out = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_seq_frame_tx_1101.sv
// Directed bench for seq_frame_tx_1101: default instance plus a PARITY_EN=0
// instance looped into a 1101 detector.
`timescale 1ns/1ps
module tb_seq_frame_tx_1101;
    logic clk = 1'b0;
    logic rst_n;
    logic out1, busy1, done1;
    logic out2, busy2, done2;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_seen = 0;
    logic [3:0] hist;
    logic det;

    always #5 clk = ~clk;

    seq_frame_tx_1101_if #(.DATA_W(8)) bus1 ();
    seq_frame_tx_1101_if #(.DATA_W(8)) bus2 ();

    seq_frame_tx_1101 #(.DATA_W(8), .SYNC(4'b1101), .PARITY_EN(1'b1), .GAP_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .hs(bus1.slave),
        .out(out1), .busy(busy1), .frame_done(done1)
    );

    seq_frame_tx_1101 #(.DATA_W(8), .SYNC(4'b1101), .PARITY_EN(1'b0), .GAP_W(2)) u_np (
        .clk(clk), .rst_n(rst_n), .hs(bus2.slave),
        .out(out2), .busy(busy2), .frame_done(done2)
    );

    // Reference 1101 detector: fires the cycle after the fourth matching bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 4'b0000;
        else        hist <= {hist[2:0], out2};
    end
    assign det = (hist == 4'b1101);

    always @(posedge clk) begin
        if (done1) done_seen <= done_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out"},   out1,           1'b0);
        chk({tag, " ready"}, bus1.ready_out, 1'b1);
        chk({tag, " busy"},  busy1,          1'b0);
        chk({tag, " done"},  done1,          1'b0);
    endtask

    // Starts in the first frame cycle; returns in the first gap cycle.
    task automatic check_frame(input string tag, input logic [12:0] exp, input int poke);
        for (int i = 0; i < 13; i++) begin
            if (i == poke) begin
                bus1.valid_in = 1'b1;
                bus1.data_in  = 8'hFF;
            end
            if (i == poke + 1) begin
                bus1.valid_in = 1'b0;
                bus1.data_in  = 8'h55;
            end
            chk({tag, " out"},   out1,           exp[12-i]);
            chk({tag, " done"},  done1,          i == 12);
            chk({tag, " busy"},  busy1,          1'b1);
            chk({tag, " ready"}, bus1.ready_out, 1'b0);
            step();
        end
    endtask

    // Two gap cycles, then stops in the IDLE cycle without advancing.
    task automatic gap_then_idle(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, " gap out"},   out1,           1'b0);
            chk({tag, " gap busy"},  busy1,          1'b1);
            chk({tag, " gap ready"}, bus1.ready_out, 1'b0);
            step();
        end
        chk({tag, " idle out"},   out1,           1'b0);
        chk({tag, " idle ready"}, bus1.ready_out, 1'b1);
        chk({tag, " idle busy"},  busy1,          1'b0);
    endtask

    initial begin
        logic [12:0] f13;
        logic [11:0] f12;
        logic [7:0]  lb_data [3];
        logic [11:0] lb_bits [3];
        int d0;
        int fires;

        rst_n = 1'b0;
        bus1.valid_in = 1'b0; bus1.data_in = 8'h00;
        bus2.valid_in = 1'b0; bus2.data_in = 8'h00;

        // Reset and idle
        repeat (3) begin
            step();
            chk_idle("reset");
        end
        rst_n = 1'b1;
        repeat (10) begin
            step();
            chk_idle("idle");
        end

        // Single frame A5: parity of 10100101 is 0
        bus1.data_in = 8'hA5; bus1.valid_in = 1'b1;
        step();
        bus1.valid_in = 1'b0; bus1.data_in = 8'h00;
        f13 = 13'b1101_10100101_0;
        check_frame("a5", f13, -10);
        gap_then_idle("a5");

        // Handshake: pulse during DATA is ignored, data_in change has no effect
        bus1.data_in = 8'h3C; bus1.valid_in = 1'b1;
        step();
        bus1.valid_in = 1'b0;
        f13 = 13'b1101_00111100_0;
        check_frame("hs", f13, 7);
        gap_then_idle("hs");
        repeat (4) begin
            step();
            chk_idle("hs after");
        end

        // Back-to-back with valid held: 16-cycle period, 3 frame_done pulses
        d0 = done_seen;
        bus1.data_in = 8'h81; bus1.valid_in = 1'b1;
        step();
        f13 = 13'b1101_10000001_0;
        for (int f = 0; f < 3; f++) begin
            check_frame("b2b", f13, -10);
            gap_then_idle("b2b");
            if (f == 2) bus1.valid_in = 1'b0;
            step();
        end
        chk_int("b2b done count", done_seen - d0, 3);
        repeat (3) begin
            chk_idle("b2b after");
            step();
        end

        // Reset during payload bit 5 of F0
        bus1.data_in = 8'hF0; bus1.valid_in = 1'b1;
        step();
        bus1.valid_in = 1'b0;
        f13 = 13'b1101_11110000_0;
        for (int i = 0; i < 6; i++) begin
            chk("abort pre out", out1, f13[12-i]);
            step();
        end
        chk("abort bit5 out", out1, 1'b1);
        d0 = done_seen;
        #2 rst_n = 1'b0;
        #1;
        chk_idle("abort async");
        repeat (2) begin
            step();
            chk_idle("abort held");
        end
        rst_n = 1'b1;
        repeat (3) begin
            step();
            chk_idle("abort released");
        end
        chk_int("abort no done", done_seen - d0, 0);
        bus1.data_in = 8'h0F; bus1.valid_in = 1'b1;
        step();
        bus1.valid_in = 1'b0;
        f13 = 13'b1101_00001111_0;
        check_frame("after abort", f13, -10);
        gap_then_idle("after abort");

        // Loopback, PARITY_EN=0, into the 1101 detector
        lb_data[0] = 8'h00; lb_bits[0] = 12'b1101_00000000;
        lb_data[1] = 8'h80; lb_bits[1] = 12'b1101_10000000;
        lb_data[2] = 8'h01; lb_bits[2] = 12'b1101_00000001;
        for (int f = 0; f < 3; f++) begin
            bus2.data_in = lb_data[f]; bus2.valid_in = 1'b1;
            step();
            bus2.valid_in = 1'b0;
            f12   = lb_bits[f];
            fires = 0;
            for (int i = 0; i < 15; i++) begin
                if (i < 12) chk("lb out", out2, f12[11-i]);
                else        chk("lb gap out", out2, 1'b0);
                chk("lb done", done2, i == 11);
                chk("lb det", det, i == 4);
                if (det) fires++;
                if (i == 14) chk("lb ready", bus2.ready_out, 1'b1);
                else         chk("lb busy", busy2, 1'b1);
                if (i < 14) step();
            end
            chk_int("lb fires", fires, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_frame_tx_1101.md
# seq_frame_tx_1101

Serial frame transmitter that produces the bit stream consumed by the team's `1101` sequence detector. It accepts a parallel payload word through a valid/ready handshake. It then shifts out a frame on a single serial line, one bit per clock: a 4-bit sync word `1101`, the payload MSB-first, and an optional even-parity bit. A mandatory run of idle zeros follows each frame so the downstream detector resynchronises between frames.

## Interface
- `DATA_W`, default 8: payload width in bits, minimum 1.
- `SYNC`, default 4'b1101: sync word, sent MSB-first.
- `PARITY_EN`, default 1: 1 appends an even-parity bit; 0 omits it.
- `GAP_W`, default 2: number of forced idle-zero bits after each frame, minimum 1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `data_in` input DATA_W: payload word, sampled only on an accepting edge.
- `valid_in` input 1: payload offered.
- `ready_out` output 1: block can accept; high only in IDLE.
- `out` output 1: serial line, registered; idles at 0.
- `busy` output 1: high in every state except IDLE.
- `frame_done` output 1: one-cycle pulse on the last frame bit.

## Operation
- States: IDLE, SYNC, DATA, PARITY, GAP.
- IDLE
  - `out`=0, `ready_out`=1.
  - An accept occurs at a rising edge where `valid_in`=1 and `ready_out`=1.
  - On accept, `data_in` is copied into an internal shift register. The parity bit (XOR of all payload bits) is computed and stored.
  - Next state is SYNC, with bit counter = 3.
- SYNC: `out`=SYNC[cnt], cnt counts 3→0. After bit 0: next state is DATA, cnt = DATA_W-1.
- DATA
  - `out`=payload[cnt], MSB-first.
  - After bit 0: next state is PARITY if PARITY_EN=1, else GAP.
- PARITY: `out`=stored parity, for one cycle. Next state is GAP.
- GAP: `out`=0 for exactly GAP_W cycles. Next state is IDLE.
- `frame_done`=1 only while the last frame bit is on `out`: the parity bit if PARITY_EN=1, otherwise payload bit 0.
- `valid_in` while `ready_out`=0 is ignored. No queueing; the upstream holds the word.
- `data_in` changes after the accepting edge do not affect the frame in flight.
- The payload is sent raw, with no stuffing. A payload containing `1101` can trigger a downstream detector; that is the user's responsibility.
- Counter width is $clog2(max(DATA_W, GAP_W, 4)). Counters never wrap in a legal sequence.

## Timing
- Reset, while `rst_n`=0 and immediately on assertion:
  - state IDLE, `out`=0, `busy`=0, `ready_out`=1, `frame_done`=0.
  - Shift register, parity and counters cleared.
- Reset mid-frame: the frame is aborted immediately and `out` drops to 0 asynchronously. After release, the block waits in IDLE for a new accept. There is no resume.
- Accept at edge k:
  - `out` shows SYNC[3] during cycle k+1.
  - Payload MSB appears during cycle k+5.
  - Last frame bit appears during cycle k+4+DATA_W+PARITY_EN.
- Frame length L = 4+DATA_W+PARITY_EN bits. Default L=13.
- `ready_out` and `busy` are decoded from the state register only, with no combinational path from `valid_in`.
- Back-to-back operation with `valid_in` held high:
  - The block returns to IDLE after GAP_W gap cycles, and the accept happens on the IDLE cycle.
  - Minimum zeros between frames = GAP_W+1.
  - Minimum frame period = L+GAP_W+1 cycles; default 16.
- `valid_in` must be synchronous to `clk`. The block has no input synchroniser.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst_n`=0 for 3 cycles, release, `valid_in`=0 for 10 cycles.
  - Response: `out`=0, `ready_out`=1, `busy`=0 and `frame_done`=0 throughout.
- Single frame, defaults:
  - Stimulus: accept `data_in`=8'hA5 at edge k.
  - Response: `out` over cycles k+1..k+13 = 1101 10100101 0.
  - `frame_done` high only in cycle k+13.
  - Then 2 gap zeros, and `ready_out`=1 at cycle k+16.
- Handshake:
  - Stimulus: accept 8'h3C, pulse `valid_in` with 8'hFF during the DATA state, then change `data_in` mid-frame.
  - Response: the 8'hFF pulse is ignored (no second frame), and the frame carries 00111100, parity 0.
- Back-to-back:
  - Stimulus: hold `valid_in`=1 with `data_in`=8'h81 for 3 frames.
  - Response: frames start every 16 cycles, exactly 3 zeros separate the frames, each parity bit is 0, and `frame_done` pulses 3 times.
- Reset mid-frame:
  - Stimulus: accept 8'hF0, drop `rst_n` during data bit 5, release, then accept 8'h0F.
  - Response: `out`=0 immediately on the reset drop, no `frame_done` for the aborted frame, and the second frame is complete and correct (1101 00001111 0).
- Loopback with PARITY_EN=0:
  - Stimulus: connect `out` to the `1101` detector and send payloads 8'h00, 8'h80, 8'h01.
  - Response: the detector fires exactly once per frame, on the cycle after the last sync bit.
  - `frame_done` coincides with payload bit 0 on `out`.
